// File: rtl/spwm_ramp_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : spwm_ramp_ctrl
// Brief    : SPWM run-time sequencer with rate-limited modulation-divider ramp
//            and a latched fault shutdown.
// Revision : 1.0
// =============================================================================
module spwm_ramp_ctrl #(
    parameter int unsigned      DIV_W    = 16,
    parameter logic [DIV_W-1:0] DIV_STOP = 16'hFFFF,
    parameter logic [DIV_W-1:0] DIV_MIN  = 16'd1,
    parameter logic [4:0]       DT_MIN   = 5'd4,
    parameter logic [7:0]       ARM_CYC  = 8'd64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_run,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic [DIV_W-1:0] cmd_carrier_div,
    input  logic [4:0]       cmd_deadtime,
    input  logic [15:0]      ramp_period,
    input  logic [DIV_W-1:0] ramp_step,
    input  logic             fault,
    input  logic             fault_clr,
    output logic [DIV_W-1:0] freq_mod_div,
    output logic [DIV_W-1:0] freq_carrier_div,
    output logic [4:0]       deadtime,
    output logic             bridge_rst_n,
    output logic             pwm_en,
    output logic             at_target,
    output logic             fault_latched,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_RAMP  = 3'd2,
        ST_RUN   = 3'd3,
        ST_STOP  = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_target;
    logic [15:0]      r_timer;
    logic [7:0]       r_arm_cnt;

    logic             w_start;
    logic             w_stop;
    logic [DIV_W-1:0] w_cmd_tgt;
    logic [4:0]       w_cmd_dt;
    logic [DIV_W-1:0] w_step;
    logic [DIV_W-1:0] w_ramp_tgt;
    logic [DIV_W-1:0] w_ramp_next;
    logic [DIV_W-1:0] w_stop_next;

    // Move cur toward tgt by stp, landing exactly on tgt instead of overshooting.
    function automatic logic [DIV_W-1:0] step_toward(input logic [DIV_W-1:0] cur,
                                                     input logic [DIV_W-1:0] tgt,
                                                     input logic [DIV_W-1:0] stp);
        logic [DIV_W-1:0] nxt;
        nxt = tgt;
        if (cur > tgt) begin
            if (cur - tgt > stp) nxt = cur - stp;
        end else if (cur < tgt) begin
            if (tgt - cur > stp) nxt = cur + stp;
        end
        return nxt;
    endfunction

    assign state     = r_state;
    assign cmd_ready = (r_state == ST_IDLE) || (r_state == ST_RAMP) || (r_state == ST_RUN);
    assign w_start   = cmd_valid && cmd_ready && cmd_run;
    assign w_stop    = cmd_valid && cmd_ready && !cmd_run;

    assign w_cmd_tgt   = (cmd_div < DIV_MIN) ? DIV_MIN : cmd_div;
    assign w_cmd_dt    = (cmd_deadtime < DT_MIN) ? DT_MIN : cmd_deadtime;
    assign w_step      = (ramp_step == '0) ? {{(DIV_W-1){1'b0}}, 1'b1} : ramp_step;
    assign w_ramp_tgt  = w_start ? w_cmd_tgt : r_target;
    assign w_ramp_next = step_toward(freq_mod_div, w_ramp_tgt, w_step);
    assign w_stop_next = step_toward(freq_mod_div, DIV_STOP, w_step);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_target         <= DIV_STOP;
            r_timer          <= '0;
            r_arm_cnt        <= '0;
            freq_mod_div     <= DIV_STOP;
            freq_carrier_div <= DIV_STOP;
            deadtime         <= DT_MIN;
            bridge_rst_n     <= 1'b0;
            pwm_en           <= 1'b0;
            at_target        <= 1'b0;
            fault_latched    <= 1'b0;
        end else if (fault) begin
            // Fault wins over any command or clear seen in the same cycle.
            r_state       <= ST_FAULT;
            freq_mod_div  <= DIV_STOP;
            bridge_rst_n  <= 1'b0;
            pwm_en        <= 1'b0;
            at_target     <= 1'b0;
            fault_latched <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    freq_mod_div  <= DIV_STOP;
                    bridge_rst_n  <= 1'b0;
                    pwm_en        <= 1'b0;
                    at_target     <= 1'b0;
                    fault_latched <= 1'b0;
                    if (w_start) begin
                        r_target         <= w_cmd_tgt;
                        freq_carrier_div <= cmd_carrier_div;
                        deadtime         <= w_cmd_dt;
                        r_arm_cnt        <= ARM_CYC - 8'd1;
                        bridge_rst_n     <= 1'b1;
                        r_state          <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (r_arm_cnt == 8'd0) begin
                        r_timer <= ramp_period;
                        pwm_en  <= 1'b1;
                        r_state <= ST_RAMP;
                    end else begin
                        r_arm_cnt <= r_arm_cnt - 8'd1;
                    end
                end
                ST_RAMP: begin
                    if (w_stop) begin
                        r_timer <= ramp_period;
                        r_state <= ST_STOP;
                    end else begin
                        if (w_start) r_target <= w_cmd_tgt;
                        if (freq_mod_div == w_ramp_tgt) begin
                            at_target <= 1'b1;
                            r_state   <= ST_RUN;
                        end else if (r_timer == 16'd0) begin
                            freq_mod_div <= w_ramp_next;
                            r_timer      <= ramp_period;
                        end else begin
                            r_timer <= r_timer - 16'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_start) begin
                        r_target  <= w_cmd_tgt;
                        r_timer   <= ramp_period;
                        at_target <= 1'b0;
                        r_state   <= ST_RAMP;
                    end else if (w_stop) begin
                        r_timer   <= ramp_period;
                        at_target <= 1'b0;
                        r_state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (freq_mod_div == DIV_STOP) begin
                        pwm_en       <= 1'b0;
                        bridge_rst_n <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else if (r_timer == 16'd0) begin
                        freq_mod_div <= w_stop_next;
                        r_timer      <= ramp_period;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        fault_latched <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spwm_ramp_ctrl.sv
`default_nettype none
// Directed vector bench for spwm_ramp_ctrl: table of per-step stimulus and
// expected outputs, plus hand-written reset sequences.
module tb_spwm_ramp_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_run = 1'b0;
    logic [15:0] cmd_div = '0;
    logic [15:0] cmd_carrier_div = '0;
    logic [4:0]  cmd_deadtime = '0;
    logic [15:0] ramp_period = '0;
    logic [15:0] ramp_step = '0;
    logic        fault = 1'b0;
    logic        fault_clr = 1'b0;
    logic [15:0] freq_mod_div;
    logic [15:0] freq_carrier_div;
    logic [4:0]  deadtime;
    logic        bridge_rst_n;
    logic        pwm_en;
    logic        at_target;
    logic        fault_latched;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spwm_ramp_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_run(cmd_run),
        .cmd_div(cmd_div), .cmd_carrier_div(cmd_carrier_div), .cmd_deadtime(cmd_deadtime),
        .ramp_period(ramp_period), .ramp_step(ramp_step),
        .fault(fault), .fault_clr(fault_clr),
        .freq_mod_div(freq_mod_div), .freq_carrier_div(freq_carrier_div),
        .deadtime(deadtime), .bridge_rst_n(bridge_rst_n), .pwm_en(pwm_en),
        .at_target(at_target), .fault_latched(fault_latched), .state(state)
    );

    // {state, mod div, carrier div, deadtime, pwm_en, bridge_rst_n, cmd_ready, at_target, fault_latched}
    wire [44:0] obs = {state, freq_mod_div, freq_carrier_div, deadtime,
                       pwm_en, bridge_rst_n, cmd_ready, at_target, fault_latched};

    localparam logic [44:0] RESET_OBS = {3'd0, 16'hFFFF, 16'hFFFF, 5'd4, 5'b00100};

    typedef struct {
        logic        valid, run;
        logic [15:0] div, cdiv;
        logic [4:0]  dt;
        logic [15:0] period, step;
        logic        flt, fclr;
        int          n;
        logic [44:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic valid, logic run, logic [15:0] div, logic [15:0] cdiv,
                                logic [4:0] dt, logic [15:0] period, logic [15:0] step,
                                logic flt, logic fclr, int n,
                                logic [2:0] e_st, logic [15:0] e_fmd, logic [15:0] e_cdiv,
                                logic [4:0] e_dt, logic e_pwm, logic e_brst, logic e_rdy,
                                logic e_at, logic e_fl);
        vec_t v;
        v.valid = valid; v.run = run; v.div = div; v.cdiv = cdiv; v.dt = dt;
        v.period = period; v.step = step; v.flt = flt; v.fclr = fclr; v.n = n;
        v.exp = {e_st, e_fmd, e_cdiv, e_dt, e_pwm, e_brst, e_rdy, e_at, e_fl};
        return v;
    endfunction

    task automatic check(input string name, input logic [44:0] got, input logic [44:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got state=%0d mod_div=%0d raw=%h, required state=%0d mod_div=%0d raw=%h",
                     name, got[44:42], got[41:26], got, exp[44:42], exp[41:26], exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        // Start from reset and ramp 65535 -> 1000 in steps of 16384, period 3.
        vecs.push_back(mk(1,1,1000,49,2,3,16384,0,0, 1, 1,16'hFFFF,49,4, 0,1,0,0,0));
        vecs.push_back(mk(0,1,1000,49,2,3,16384,0,0,63, 1,16'hFFFF,49,4, 0,1,0,0,0));
        vecs.push_back(mk(0,1,1000,49,2,3,16384,0,0, 1, 2,16'hFFFF,49,4, 1,1,1,0,0));
        vecs.push_back(mk(0,1,1000,49,2,3,16384,0,0, 3, 2,16'hFFFF,49,4, 1,1,1,0,0));
        vecs.push_back(mk(0,1,1000,49,2,3,16384,0,0, 1, 2,49151,   49,4, 1,1,1,0,0));
        vecs.push_back(mk(0,1,1000,49,2,3,16384,0,0, 4, 2,32767,   49,4, 1,1,1,0,0));
        vecs.push_back(mk(0,1,1000,49,2,3,16384,0,0, 4, 2,16383,   49,4, 1,1,1,0,0));
        vecs.push_back(mk(0,1,1000,49,2,3,16384,0,0, 4, 2,1000,    49,4, 1,1,1,0,0));
        vecs.push_back(mk(0,1,1000,49,2,3,16384,0,0, 1, 3,1000,    49,4, 1,1,1,1,0));
        // Retarget up by 10 with step 16: lands exactly on 1010; carrier/deadtime untouched.
        vecs.push_back(mk(1,1,1010,100,20,3,16,0,0, 1, 2,1000, 49,4, 1,1,1,0,0));
        vecs.push_back(mk(0,1,1010,100,20,3,16,0,0, 3, 2,1000, 49,4, 1,1,1,0,0));
        vecs.push_back(mk(0,1,1010,100,20,3,16,0,0, 1, 2,1010, 49,4, 1,1,1,0,0));
        vecs.push_back(mk(0,1,1010,100,20,3,16,0,0, 1, 3,1010, 49,4, 1,1,1,1,0));
        vecs.push_back(mk(1,1,1000,49,2,3,16,0,0,   1, 2,1010, 49,4, 1,1,1,0,0));
        vecs.push_back(mk(0,1,1000,49,2,3,16,0,0,   4, 2,1000, 49,4, 1,1,1,0,0));
        vecs.push_back(mk(0,1,1000,49,2,3,16,0,0,   1, 3,1000, 49,4, 1,1,1,1,0));
        // Stop with period 0, step 32768: 1000 -> 33768 -> 65535 -> IDLE.
        vecs.push_back(mk(1,0,1000,49,2,0,32768,0,0, 1, 4,1000,    49,4, 1,1,0,0,0));
        vecs.push_back(mk(0,0,1000,49,2,0,32768,0,0, 1, 4,33768,   49,4, 1,1,0,0,0));
        vecs.push_back(mk(0,0,1000,49,2,0,32768,0,0, 1, 4,65535,   49,4, 1,1,0,0,0));
        vecs.push_back(mk(0,0,1000,49,2,0,32768,0,0, 1, 0,16'hFFFF,49,4, 0,0,1,0,0));
        vecs.push_back(mk(1,0,1000,49,2,0,32768,0,0, 1, 0,16'hFFFF,49,4, 0,0,1,0,0));
        vecs.push_back(mk(0,0,1000,49,2,0,32768,0,0, 2, 0,16'hFFFF,49,4, 0,0,1,0,0));
        // Clamping: cmd_div=0 -> target 1, ramp_step=0 -> steps of 1; ready low in ARM.
        vecs.push_back(mk(1,1,0,7,9,0,0,0,0,  1, 1,16'hFFFF,7,9, 0,1,0,0,0));
        vecs.push_back(mk(0,1,0,7,9,0,0,0,0, 63, 1,16'hFFFF,7,9, 0,1,0,0,0));
        vecs.push_back(mk(0,1,0,7,9,0,0,0,0,  1, 2,16'hFFFF,7,9, 1,1,1,0,0));
        vecs.push_back(mk(0,1,0,7,9,0,0,0,0,  1, 2,65534,   7,9, 1,1,1,0,0));
        vecs.push_back(mk(0,1,0,7,9,0,0,0,0,  1, 2,65533,   7,9, 1,1,1,0,0));
        // Fault mid-ramp with a start in the same cycle; clear ignored while fault held.
        vecs.push_back(mk(1,1,500,300,1,0,0,1,0, 1, 5,16'hFFFF,7,9, 0,0,0,0,1));
        vecs.push_back(mk(0,1,500,300,1,0,0,1,1, 1, 5,16'hFFFF,7,9, 0,0,0,0,1));
        vecs.push_back(mk(0,1,500,300,1,0,0,0,1, 1, 0,16'hFFFF,7,9, 0,0,1,0,0));
        vecs.push_back(mk(0,1,500,300,1,0,0,0,0, 2, 0,16'hFFFF,7,9, 0,0,1,0,0));

        // Power-up reset values.
        repeat (3) @(posedge clk);
        #1 check("power_up_reset", obs, RESET_OBS);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 check("idle_after_reset", obs, RESET_OBS);

        foreach (vecs[i]) begin
            cmd_valid = vecs[i].valid; cmd_run = vecs[i].run; cmd_div = vecs[i].div;
            cmd_carrier_div = vecs[i].cdiv; cmd_deadtime = vecs[i].dt;
            ramp_period = vecs[i].period; ramp_step = vecs[i].step;
            fault = vecs[i].flt; fault_clr = vecs[i].fclr;
            repeat (vecs[i].n) @(posedge clk);
            #1 check($sformatf("vec%0d", i), obs, vecs[i].exp);
        end

        // Reset asserted mid-RAMP clears outputs without waiting for a clock edge.
        cmd_valid = 1'b1; cmd_run = 1'b1; cmd_div = 16'd1000; cmd_carrier_div = 16'd49;
        cmd_deadtime = 5'd2; ramp_period = 16'd3; ramp_step = 16'd16384;
        fault = 1'b0; fault_clr = 1'b0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (66) @(posedge clk);
        #1 check("pre_reset_ramp", obs, {3'd2, 16'hFFFF, 16'd49, 5'd4, 5'b11100});
        #3 rst_n = 1'b0;
        #1 check("async_reset_mid_ramp", obs, RESET_OBS);
        @(negedge clk) rst_n = 1'b1;

        // Next start behaves as from power-up.
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 check("restart_arm", obs, {3'd1, 16'hFFFF, 16'd49, 5'd4, 5'b01000});
        cmd_valid = 1'b0;
        repeat (64) @(posedge clk);
        #1 check("restart_ramp_entry", obs, {3'd2, 16'hFFFF, 16'd49, 5'd4, 5'b11100});
        repeat (4) @(posedge clk);
        #1 check("restart_first_step", obs, {3'd2, 16'd49151, 16'd49, 5'd4, 5'b11100});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spwm_ramp_ctrl.md
# spwm_ramp_ctrl

Run-time sequencer for the three-phase SPWM datapath. It takes start, retarget and stop commands over a valid/ready handshake and drives the datapath configuration: carrier divider, modulation divider, deadtime, datapath reset and gate enable. Frequency changes are applied as a rate-limited ramp on the modulation divider. An external fault input latches a shutdown state. The block sits between the host/register interface and the SPWM top-level, and runs on the same 50 MHz clock.

## Interface
- DIV_W, 16, width of all divider values.
- DIV_STOP, 16'hFFFF, modulation divider for idle/stopped (slowest); stop ramps end here.
- DIV_MIN, 16'd1, minimum legal modulation divider; smaller targets are clamped up to it.
- DT_MIN, 5'd4, minimum deadtime; smaller requests are clamped up to it.
- ARM_CYC, 8'd64, clocks spent in ARM before gating starts.

- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_run  in  1  1 = start/retarget, 0 = stop.
- cmd_div  in  DIV_W  target modulation divider.
- cmd_carrier_div  in  DIV_W  carrier divider; used only when a start is accepted in IDLE.
- cmd_deadtime  in  5  deadtime; used only when a start is accepted in IDLE.
- ramp_period  in  16  clocks between ramp steps, minus 1; sampled live.
- ramp_step  in  DIV_W  divider change per step; 0 is treated as 1.
- fault  in  1  level fault from the power stage (synchronous to clk).
- fault_clr  in  1  request to leave FAULT.
- freq_mod_div  out  DIV_W  to the datapath modulation divider.
- freq_carrier_div  out  DIV_W  to the datapath carrier divider.
- deadtime  out  5  to the deadtime driver.
- bridge_rst_n  out  1  datapath reset, active low.
- pwm_en  out  1  gate enable; the downstream AND gates all six outputs with it.
- at_target  out  1  high in RUN.
- fault_latched  out  1  high in FAULT.
- state  out  3  IDLE=0, ARM=1, RAMP=2, RUN=3, STOP=4, FAULT=5.

## Operation
**Registered outputs and reset values**
- All outputs except cmd_ready are registered.
- Reset values:
  - state = IDLE
  - freq_mod_div = DIV_STOP
  - freq_carrier_div = DIV_STOP
  - deadtime = DT_MIN
  - bridge_rst_n = 0
  - pwm_en = 0
  - at_target = 0
  - fault_latched = 0
- cmd_ready is decoded combinationally from state: 1 in IDLE, RAMP and RUN; 0 in ARM, STOP and FAULT.

**States**
- IDLE
  - Outputs: bridge_rst_n=0, pwm_en=0, freq_mod_div=DIV_STOP.
  - Start accepted: latch target=max(cmd_div, DIV_MIN), carrier div, and deadtime=max(cmd_deadtime, DT_MIN); go to ARM.
  - Stop accepted: no effect.
- ARM
  - Outputs: bridge_rst_n=1, pwm_en=0.
  - Stays exactly ARM_CYC clocks, then goes to RAMP.
- RAMP
  - Outputs: bridge_rst_n=1, pwm_en=1.
  - Step timer loads ramp_period on entry and after each step; a step occurs when the timer equals 0.
  - Step rule, using unsigned differences with no wrap:
    - if cur>tgt: cur = (cur−tgt > step) ? cur−step : tgt
    - if cur<tgt: cur = (tgt−cur > step) ? cur+step : tgt
  - cur==tgt goes to RUN on the next clock.
  - Start accepted: replaces the target (clamped); timer is not reloaded.
  - Stop accepted: go to STOP.
- RUN
  - Output: at_target=1.
  - Start accepted: new target, go to RAMP (timer reloaded).
  - Stop accepted: go to STOP.
  - A retarget equal to cur still passes through RAMP for one clock.
- STOP
  - Ramps toward DIV_STOP using the same step rule; pwm_en=1.
  - On reaching DIV_STOP: go to IDLE and drop pwm_en and bridge_rst_n.
- FAULT
  - Outputs: pwm_en=0, bridge_rst_n=0, fault_latched=1, freq_mod_div=DIV_STOP.
  - Exits to IDLE when fault_clr=1 and fault=0.

**Priorities**
- fault=1 in any state forces FAULT on the next clock.
- fault overrides any command accepted in the same cycle and overrides fault_clr.
- A handshake that completes in a faulting cycle is consumed and discarded.

## Timing
- A command handshake completes on a rising edge with cmd_valid & cmd_ready; state and outputs change on that edge.
- pwm_en falls on the first edge at which fault is sampled high (1-clock latency).
- ARM→RAMP: ARM_CYC clocks after ARM entry.
- First ramp step: ramp_period+1 clocks after RAMP entry; subsequent steps every ramp_period+1 clocks.
- freq_carrier_div and deadtime change only on the IDLE→ARM edge, so they are never modified while pwm_en=1.
- Asserting reset mid-ramp immediately returns all outputs to their reset values.

## Test plan
- **Start and ramp down:** start cmd_div=1000, carrier 49, deadtime 2, ramp_period 3, step 16384, from reset → deadtime=4; ARM lasts 64 clks; freq_mod_div goes 65535→49151→32767→16383→1000 at 4-clk intervals; RUN with at_target=1.
- **Overshoot clamp and retarget up:** in RUN at 1000, retarget cmd_div=1010, step 16 → a single step to exactly 1010, then RUN; no overshoot.
- **Stop:** stop from RUN at 1000, step 32768, period 0 → 1000→33768→65535, then IDLE with pwm_en=0 and bridge_rst_n=0; a stop accepted in IDLE changes nothing.
- **Fault mid-ramp:** fault during RAMP with a start cmd in the same cycle → next clock FAULT, pwm_en=0, command dropped; fault_clr while fault=1 is ignored; fault=0 with fault_clr=1 → IDLE.
- **Clamping:** cmd_div=0 and ramp_step=0 → target 1, steps of 1; cmd_ready=0 throughout ARM and STOP.
- **Reset mid-RAMP:** assert reset during RAMP → all outputs at reset values asynchronously; the next start behaves as from power-up.
